// File: rtl/pa_spsram_256x4_ctrl.sv
// Valid/ready front end for a 256x4 single-port SRAM macro with a 1-entry read response hold buffer.
// Define PA_SPSRAM_CTRL_INIT_EN to add a post-reset sweep that writes INIT_VAL to every entry.
module pa_spsram_256x4_ctrl #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    logic                  run;
    logic                  init_act;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  rd_pend;
    logic                  hold_vld;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  rd_ok;
    logic                  wr_xfer;
    logic                  rd_xfer;

`ifdef PA_SPSRAM_CTRL_INIT_EN
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == '1)
                state <= ST_RUN;
        end
    end

    assign run       = (state == ST_RUN) & ~cpurst;
    assign init_act  = (state == ST_INIT) & ~cpurst;
    assign init_addr = cnt;
`else
    assign run       = ~cpurst;
    assign init_act  = 1'b0;
    assign init_addr = '0;
`endif

    // Only one read may be in flight: a new read waits until the previous one can drain.
    assign rd_ok     = ~hold_vld & ~(rd_pend & ~rsp_rdy);
    assign req_rdy   = run & (req_wr | rd_ok);
    assign wr_xfer   = req_vld & req_rdy & req_wr;
    assign rd_xfer   = req_vld & req_rdy & ~req_wr;
    assign init_done = run;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (init_act) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = init_addr;
            sram_d    = INIT_VAL;
        end else if (wr_xfer) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = ~req_wmask;
            sram_a    = req_addr;
            sram_d    = req_wdata;
        end else if (rd_xfer) begin
            sram_cen  = 1'b0;
            sram_a    = req_addr;
        end
    end

    // Macro Q is only valid for one cycle, so a stalled response is parked in hold_q.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            rd_pend  <= 1'b0;
            hold_vld <= 1'b0;
            hold_q   <= '0;
        end else begin
            rd_pend <= rd_xfer;
            if (rd_pend && !rsp_rdy) begin
                hold_vld <= 1'b1;
                hold_q   <= sram_q;
            end else if (hold_vld && rsp_rdy) begin
                hold_vld <= 1'b0;
            end
        end
    end

    assign rsp_vld   = hold_vld | rd_pend;
    assign rsp_rdata = cpurst ? '0 : (hold_vld ? hold_q : sram_q);

endmodule
